ice_bus_arbiter: RTL
====================

Name: ice_bus_arbiter

Overview:
- Parametrised arbiter for the ice slave-output bus (sl_data/sl_addr/sl_tail).
- Grants exactly one of NUM_DEV requesters ownership for one whole frame; ownership is released on the tail latch.
- Two arbitration modes, selectable at run time: fixed priority and round-robin.
- A watchdog revokes any grant held too long, so a hung interface (MBus, PMU, EIN, ...) cannot lock out the others.

Parameters:
- NUM_DEV, 7, number of requesters; legal range 2..32.
- TIMEOUT_W, 16, width of the grant watchdog counter.
- TIMEOUT_CYC, 16'hFFFF, clk cycles a grant may be held before revocation; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sl_arb_request  in  NUM_DEV  per-device request; level, held until the frame is done.
- sl_latch_tail  in  1  single-cycle pulse from the current owner marking end of frame.
- rr_mode  in  1  0 = fixed priority (index 0 highest); 1 = round-robin.
- sl_arb_grant  out  NUM_DEV  one-hot or zero grant, registered.
- grant_idx  out  IDX_W  encoded index of the owner; IDX_W = max(1, clog2(NUM_DEV)).
- busy  out  1  high while any grant is held.
- arb_timeout  out  1  single-cycle pulse when the watchdog revokes a grant.
- timeout_idx  out  IDX_W  index of the last revoked owner; sticky until the next timeout.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears all outputs:
  - sl_arb_grant = 0, grant_idx = 0, busy = 0, arb_timeout = 0, timeout_idx = 0.
  - rr_ptr = NUM_DEV-1, so device 0 is searched first.
  - Watchdog counter = 0; state = IDLE.
- IDLE:
  - If any request is set, pick a winner and register it. The grant is visible the cycle after the request is sampled (1-cycle latency). Go to GRANT.
  - Fixed mode: lowest set index wins.
  - RR mode: search from rr_ptr+1 upward, wrapping modulo NUM_DEV. rr_ptr loads the winner index when the grant is issued.
  - rr_mode is sampled only in IDLE; a change during GRANT takes effect at the next arbitration.
- GRANT:
  - sl_arb_grant is held constant and busy = 1; the watchdog counts up each cycle.
  - sl_latch_tail = 1: drop the grant next cycle and go to RELEASE.
  - Owner drops its request without a tail (abort): treated identically to a tail.
  - Watchdog reaches TIMEOUT_CYC - 1 with no tail:
    - drop the grant;
    - pulse arb_timeout for 1 cycle;
    - load timeout_idx = grant_idx;
    - go to RELEASE.
  - Tail and timeout in the same cycle: tail wins; no arb_timeout pulse.
  - sl_latch_tail while in IDLE or RELEASE is ignored.
- RELEASE: one mandatory dead cycle with grant = 0 so bus drivers can tristate/mux, then IDLE. Back-to-back frames therefore have a minimum 2-cycle grant gap.
- Watchdog counter clears on entry to GRANT and saturates; it never wraps.
- A request from a non-owner during GRANT never affects the current grant.
- Asserting reset_n low mid-frame drops the grant immediately (asynchronous).
- Width rules:
  - grant_idx is the binary encoding of the one-hot grant.
  - Unused encodings (NUM_DEV not a power of two) are never produced.

Optional Feature:
- Macro: ICE_BUS_ARB_GRANT_STATS_EN.
- With it defined:
  - Adds an output grant_count of width 8*NUM_DEV: one saturating 8-bit counter per device, incremented when that device is granted.
  - Adds an input stats_clear (1-bit, synchronous) that zeroes all counters; clear wins over a simultaneous increment.
- Without it: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ice_bus_pkg:
  - arbiter state encoding (ARB_IDLE, ARB_GRANT, ARB_RELEASE);
  - IDX_W calculation function;
  - default TIMEOUT_CYC constant.
- One sub-module, ice_bus_rr_pick: combinational masked priority picker. Inputs are request vector, start pointer and mode; outputs are one-hot winner and index. It is instantiated once, reused for both modes (fixed = start pointer forced to NUM_DEV-1).

Test Plan:
- Fixed mode, NUM_DEV=7: request = 7'b1010100 → grant 7'b0000100 one cycle later, grant_idx = 2; tail pulse → grant 0 for 2 cycles, then 7'b0010000.
- RR mode: requests 0, 3 and 5 held continuously, tail each frame → grant sequence 0, 3, 5, 0, 3 with grant_idx matching.
- Watchdog: TIMEOUT_CYC = 8, device 4 granted with no tail → grant drops after 8 cycles, arb_timeout pulses once, timeout_idx = 4; device 1 granted after RELEASE.
- Tail in the exact timeout cycle → no arb_timeout, timeout_idx unchanged.
- Owner drops its request mid-frame → same release timing as a tail; then reset_n pulsed low during a later grant → all outputs 0 asynchronously, rr_ptr restarts at device 0.
- With ICE_BUS_ARB_GRANT_STATS_EN: device 6 granted 300 times → grant_count[55:48] = 8'hFF (saturated); stats_clear → 0.

Source files
------------

// File: rtl/ice_bus_pkg.sv
// Shared definitions for the ice slave-output bus arbiter: state encoding,
// index-width helper and the default watchdog limit.
package ice_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // A grant may be held this many cycles before the watchdog revokes it.
  localparam int unsigned DefaultTimeoutCyc = 32'h0000_FFFF;

  // Width of an encoded device index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ice_bus_rr_pick.sv
// Combinational masked priority picker. Searches upward from start_i + 1,
// wrapping modulo NUM_DEV. Fixed priority is the same search with the start
// forced to NUM_DEV-1, so index 0 is examined first.
module ice_bus_rr_pick
  import ice_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV = 7,
  localparam int unsigned IDX_W  = idx_w(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  input  logic               rr_mode_i,
  output logic [NUM_DEV-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] start;
  logic [IDX_W:0]   cand;   // one spare bit holds start + k before the wrap
  logic             found;

  // First requester at or after start+1 (mod NUM_DEV) wins.
  always_comb begin
    start    = rr_mode_i ? start_i : IDX_W'(NUM_DEV - 1);
    cand     = '0;
    found    = 1'b0;
    winner_o = '0;
    idx_o    = '0;
    for (int unsigned k = 1; k <= NUM_DEV; k++) begin
      cand = {1'b0, start} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_DEV)) begin
        cand = cand - (IDX_W + 1)'(NUM_DEV);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                       = 1'b1;
        winner_o[cand[IDX_W-1:0]]   = 1'b1;
        idx_o                       = cand[IDX_W-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ice_bus_arbiter.sv
// Frame-level arbiter for the ice slave-output bus. One requester owns the bus
// from grant until its tail latch (or request drop), followed by one dead
// cycle. A watchdog revokes grants held too long.
// Optional: define ICE_BUS_ARB_GRANT_STATS_EN for per-device saturating grant
// counters (grant_count) with a synchronous stats_clear.
module ice_bus_arbiter
  import ice_bus_pkg::*;
#(
  parameter int unsigned NUM_DEV     = 7,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc,
  localparam int unsigned IDX_W      = idx_w(NUM_DEV)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_DEV-1:0]   sl_arb_request,
  input  logic                 sl_latch_tail,
  input  logic                 rr_mode,
  output logic [NUM_DEV-1:0]   sl_arb_grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 arb_timeout,
`ifdef ICE_BUS_ARB_GRANT_STATS_EN
  input  logic                 stats_clear,
  output logic [8*NUM_DEV-1:0] grant_count,
`endif
  output logic [IDX_W-1:0]     timeout_idx
);

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_DEV-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
  logic                   tout_q, tout_d;
  logic [IDX_W-1:0]       tout_idx_q, tout_idx_d;

  logic [NUM_DEV-1:0]     pick_winner;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   grant_issue;

  ice_bus_rr_pick #(
    .NUM_DEV (NUM_DEV)
  ) u_pick (
    .req_i     (sl_arb_request),
    .start_i   (rr_ptr_q),
    .rr_mode_i (rr_mode),
    .winner_o  (pick_winner),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  // Next-state logic for the arbitration FSM, watchdog and timeout reporting.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    tout_d      = 1'b0;
    tout_idx_d  = tout_idx_q;
    grant_issue = 1'b0;
    // Owner still requesting; a drop is an abort and ends the frame like a tail.
    owner_req   = |(sl_arb_request & grant_q);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_issue = 1'b1;
          grant_d     = pick_winner;
          grant_idx_d = pick_idx;
          wdog_d      = '0;
          if (rr_mode) begin
            rr_ptr_d = pick_idx;
          end
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (sl_latch_tail || !owner_req) begin
          grant_d     = '0;
          grant_idx_d = '0;
          state_d     = ARB_RELEASE;
        end else if (wdog_q == TimeoutLast) begin
          grant_d     = '0;
          grant_idx_d = '0;
          tout_d      = 1'b1;
          tout_idx_d  = grant_idx_q;
          state_d     = ARB_RELEASE;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
        state_d     = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= IDX_W'(NUM_DEV - 1);
      wdog_q      <= '0;
      tout_q      <= 1'b0;
      tout_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
      tout_q      <= tout_d;
      tout_idx_q  <= tout_idx_d;
    end
  end

  assign sl_arb_grant = grant_q;
  assign grant_idx    = grant_idx_q;
  assign busy         = (state_q == ARB_GRANT);
  assign arb_timeout  = tout_q;
  assign timeout_idx  = tout_idx_q;

`ifdef ICE_BUS_ARB_GRANT_STATS_EN
  logic [NUM_DEV-1:0][7:0] cnt_q, cnt_d;

  // Per-device saturating grant counters; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (stats_clear) begin
        cnt_d[i] = '0;
      end else if (grant_issue && pick_winner[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule
